alu_issue: RTL

Decode/issue stage that drives the ALU interface. It accepts one RISC-V RV32I instruction per handshake, together with its PC and register-file operands. It decodes the ALU operation and selects the operands, then presents them on a registered valid/ready output to the execute stage, whose ALU consumes ALUOp, inputA and inputB. A 2-entry skid buffer (output register plus skid register) gives full throughput with a registered in_ready.

---
 rtl/alu_issue.sv | 222 ++++++++++++++++++++++
 1 files changed

// File: rtl/alu_issue.sv
// RV32I decode/issue stage: decodes the ALU operation and operands and presents them
// through a 2-entry (output + skid) valid/ready buffer with a registered in_ready.
package cpu_pkg;
   typedef enum logic [3:0] {
      ALU_ADD  = 4'd0,
      ALU_SUB  = 4'd1,
      ALU_SLL  = 4'd2,
      ALU_SLT  = 4'd3,
      ALU_SLTU = 4'd4,
      ALU_XOR  = 4'd5,
      ALU_SRL  = 4'd6,
      ALU_SRA  = 4'd7,
      ALU_OR   = 4'd8,
      ALU_AND  = 4'd9
   } alu_op_t;
endpackage

module alu_issue
   import cpu_pkg::*;
#(
   parameter int unsigned XLEN = 32
) (
   input  logic            clk,
   input  logic            nRst,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     instr,
   input  logic [XLEN-1:0] pc,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output alu_op_t         ALUOp,
   output logic [XLEN-1:0] inputA,
   output logic [XLEN-1:0] inputB,
   output logic [4:0]      rd,
   output logic            reg_write,
   output logic            is_branch,
   output logic [2:0]      br_funct3,
   output logic            illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      alu_op_t         op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [4:0]      rd;
      logic            reg_write;
      logic            is_branch;
      logic [2:0]      br_funct3;
      logic            illegal;
   } beat_t;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_i;
   logic [XLEN-1:0] imm_u;
   logic [XLEN-1:0] shamt_i;
   logic [XLEN-1:0] shamt_r;

   assign opcode  = instr[6:0];
   assign funct3  = instr[14:12];
   assign funct7  = instr[31:25];
   assign imm_i   = {{(XLEN-12){instr[31]}}, instr[31:20]};
   assign imm_u   = {instr[31:12], 12'b0};
   assign shamt_i = {{(XLEN-5){1'b0}}, instr[24:20]};
   assign shamt_r = {{(XLEN-5){1'b0}}, rs2_data[4:0]};

   beat_t   dec;
   alu_op_t dec_op;
   logic [XLEN-1:0] dec_a;
   logic [XLEN-1:0] dec_b;
   logic    dec_rw;
   logic    dec_br;
   logic    legal;

   always_comb begin
      dec_op = ALU_ADD;
      dec_a  = '0;
      dec_b  = '0;
      dec_rw = 1'b0;
      dec_br = 1'b0;
      legal  = 1'b1;
      case (opcode)
         OPC_OP, OPC_OPIMM: begin
            dec_a  = rs1_data;
            dec_b  = (opcode == OPC_OP) ? rs2_data : imm_i;
            dec_rw = 1'b1;
            case (funct3)
               3'b000: dec_op = (opcode == OPC_OP && funct7 == F7_ALT) ? ALU_SUB : ALU_ADD;
               3'b001: dec_op = ALU_SLL;
               3'b010: dec_op = ALU_SLT;
               3'b011: dec_op = ALU_SLTU;
               3'b100: dec_op = ALU_XOR;
               3'b101: dec_op = (funct7 == F7_ALT) ? ALU_SRA : ALU_SRL;
               3'b110: dec_op = ALU_OR;
               default: dec_op = ALU_AND;
            endcase
            // Shift amounts are masked to 5 bits because the ALU shifts by the full inputB.
            if (funct3 == 3'b001 || funct3 == 3'b101)
               dec_b = (opcode == OPC_OP) ? shamt_r : shamt_i;
            if (opcode == OPC_OP)
               legal = (funct7 == F7_ZERO) ||
                       (funct7 == F7_ALT && (funct3 == 3'b000 || funct3 == 3'b101));
            else if (funct3 == 3'b001)
               legal = (funct7 == F7_ZERO);
            else if (funct3 == 3'b101)
               legal = (funct7 == F7_ZERO) || (funct7 == F7_ALT);
         end
         OPC_LUI: begin
            dec_b  = imm_u;
            dec_rw = 1'b1;
         end
         OPC_AUIPC: begin
            dec_a  = pc;
            dec_b  = imm_u;
            dec_rw = 1'b1;
         end
         OPC_BRANCH: begin
            dec_a  = rs1_data;
            dec_b  = rs2_data;
            dec_br = 1'b1;
            case (funct3)
               3'b000, 3'b001: dec_op = ALU_SUB;
               3'b100, 3'b101: dec_op = ALU_SLT;
               3'b110, 3'b111: dec_op = ALU_SLTU;
               default:        legal  = 1'b0;
            endcase
         end
         default: legal = 1'b0;
      endcase

      if (!legal) begin
         dec_op = ALU_ADD;
         dec_a  = '0;
         dec_b  = '0;
         dec_rw = 1'b0;
         dec_br = 1'b0;
      end

      dec.op        = dec_op;
      dec.a         = dec_a;
      dec.b         = dec_b;
      dec.rd        = instr[11:7];
      dec.reg_write = dec_rw;
      dec.is_branch = dec_br;
      dec.br_funct3 = funct3;
      dec.illegal   = !legal;
   end

   beat_t out_q, out_d;
   beat_t skid_q, skid_d;
   logic  out_valid_q, out_valid_d;
   logic  skid_valid_q, skid_valid_d;
   logic  accept;
   logic  fire;

   assign accept = in_valid & ~skid_valid_q;
   assign fire   = out_valid_q & out_ready;

   always_comb begin
      out_d        = out_q;
      skid_d       = skid_q;
      out_valid_d  = out_valid_q;
      skid_valid_d = skid_valid_q;
      if (flush) begin
         out_valid_d  = 1'b0;
         skid_valid_d = 1'b0;
      end else if (skid_valid_q) begin
         if (fire) begin
            out_d        = skid_q;
            skid_valid_d = 1'b0;
         end
      end else if (accept) begin
         if (!out_valid_q || fire) begin
            out_d       = dec;
            out_valid_d = 1'b1;
         end else begin
            skid_d       = dec;
            skid_valid_d = 1'b1;
         end
      end else if (fire) begin
         out_valid_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge nRst) begin
      if (!nRst) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else begin
         out_q        <= out_d;
         skid_q       <= skid_d;
         out_valid_q  <= out_valid_d;
         skid_valid_q <= skid_valid_d;
      end
   end

   assign in_ready  = ~skid_valid_q;
   assign out_valid = out_valid_q;
   assign ALUOp     = out_q.op;
   assign inputA    = out_q.a;
   assign inputB    = out_q.b;
   assign rd        = out_q.rd;
   assign reg_write = out_q.reg_write;
   assign is_branch = out_q.is_branch;
   assign br_funct3 = out_q.br_funct3;
   assign illegal   = out_q.illegal;

endmodule
